sha256_core: RTL and testbench
==============================

# sha256_core

Iterative, parametrised SHA-256 compression engine that processes one 512-bit message block per transaction and maintains the chaining value across blocks. It builds on the team's single-round SHA-256 datapath: it adds the message schedule, the round-constant sequencing, a valid/ready handshake and the final feed-forward addition. A configurable number of rounds is unrolled per clock. The block sits between the padding/framing logic upstream and the digest consumer downstream.

## Interface
- `ROUNDS_PER_CYCLE`, default 1: rounds executed per clock. Legal values are 1, 2, 4, 8 and 16. Any other value is an elaboration error.
- `clk` input, 1 bit: sole clock. All state changes on the rising edge.
- `rst` input, 1 bit: asynchronous, active-high reset.
- `in_valid` input, 1 bit: `block_in`/`chain` are valid.
- `in_ready` output, 1 bit: core can accept a block.
- `block_in` input, 512 bits: already-padded message block. W0 = `block_in[511:480]`, W15 = `block_in[31:0]`.
- `chain` input, 1 bit, sampled with the block:
  - 0: start from the standard IV.
  - 1: continue from the current H.
- `out_valid` output, 1 bit: `digest` holds the result for the last accepted block.
- `digest` output, 256 bits: H0 = `digest[255:224]` … H7 = `digest[31:0]`.

## Operation
- **States:** IDLE, ROUND, FINAL, DONE.
- **`in_ready`:** 1 in IDLE and DONE, 0 in ROUND and FINAL. `in_valid` is ignored when `in_ready` = 0. Data is not latched and there is no error.
- **Accept:** occurs when `in_valid` & `in_ready` at an edge. On that edge:
  - H is set to IV if `chain` = 0; otherwise H is unchanged.
  - a..h are loaded from the selected H.
  - The 16-word W window is loaded from `block_in`.
  - The round counter is cleared to 0.
  - `out_valid` is cleared.
  - State goes to ROUND.
- **ROUND:** each edge applies `ROUNDS_PER_CYCLE` chained rounds j..j+R-1 using K[j] and Wj. The window then slides by R words, with new words computed as σ1(W[t-2]) + W[t-7] + σ0(W[t-15]) + W[t-16]. The counter increments by R. When the counter reaches 64, state goes to FINAL.
- **FINAL:** on one edge, Hi is updated to Hi + {a..h}i, each sum mod 2^32. `out_valid` is set to 1 and state goes to DONE.
- **DONE:** `digest` = H and is held stable. `out_valid` stays 1 until the next accept or reset.
- **Arithmetic:** all additions are 32-bit with wrap-around and no carry out. Rotates are as specified in FIPS 180-4.
- **Message schedule:** words 16..63 are generated on the fly. No 64-word storage.

## Timing
- **Reset values:**
  - state = IDLE.
  - `in_ready` = 1.
  - `out_valid` = 0.
  - H = IV, so `digest` = 6a09e667 bb67ae85 3c6ef372 a54ff53a 510e527f 9b05688c 1f83d9ab 5be0cd19.
  - a..h = 0, window = 0, counter = 0.
- **Latency:** `out_valid` rises 64/R + 1 edges after the accept edge. That is 65 edges for R=1 and 5 edges for R=16.
- **Throughput:** one block every 64/R + 2 cycles when the upstream drives `in_valid` continuously. The DONE cycle doubles as the next accept cycle.
- **Accept in DONE:** `out_valid` falls on that same edge. Back-to-back `chain` = 1 blocks therefore use the just-finalised H.
- **Reset mid-operation:** any state returns to IDLE immediately with the reset values above. The partial block is discarded.
- **`chain` = 1 after reset:** continues from IV, which is identical to `chain` = 0.

## Structure
- **Package `sha256_pkg`:**
  - K[0:63] constant array.
  - IV constant.
  - State enum.
  - Functions `ep0`, `ep1`, `sig0`, `sig1`, `ch`, `maj`.
- **Sub-module `sha256_round_unit`:**
  - Purely combinational single round: inputs a..h, Kj, Wj; outputs a..h.
  - The core instantiates `ROUNDS_PER_CYCLE` copies in a generate chain.
  - K for the chain is indexed by counter + i.
- The core contains the FSM, counter, W window, H register and feed-forward adders.

## Test plan
- **"abc" single block**, `chain` = 0, R=1: expect `digest` = ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad, with `out_valid` exactly 65 edges after accept.
- **Empty-message padded block** (80000000, zeros, length 0): expect e3b0c442 98fc1c14 9afbf4c8 996fb924 27ae41e4 649b934c a495991b 7852b855. Repeat for R = 2, 4, 8, 16, checking latency 64/R + 1 each time.
- **Two-block "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq"**: send block 1 with `chain` = 0, then block 2 with `chain` = 1, accepted back-to-back in DONE. Expect 248d6a61 d20638b8 e5c02693 0c3e6039 a33ce459 64ff2167 f6ecedd4 19db06c1.
- **`in_valid` held during ROUND** with a different block: no effect on the result. The "abc" digest is unchanged and `in_ready` = 0 throughout.
- **`rst` pulsed at round 30 of a block:**
  - Next cycle: `out_valid` = 0, `in_ready` = 1, `digest` = IV.
  - A subsequent "abc" block with `chain` = 1 still yields the ba7816bf… digest.

Source files
------------

// File: rtl/sha256_pkg.sv
// SHA-256 shared definitions: round constants, initial hash value, FSM states
// and the FIPS 180-4 logical functions used by the round unit and the schedule.
// Latency: n/a (constants and pure functions only). Backpressure: n/a.
package sha256_pkg;

  // Working variables a..h; a sits in the MSBs so a 256-bit H/IV maps H0 -> a.
  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] c;
    logic [31:0] d;
    logic [31:0] e;
    logic [31:0] f;
    logic [31:0] g;
    logic [31:0] h;
  } work_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ROUND = 2'd1,
    ST_FINAL = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam logic [255:0] IV = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  localparam logic [31:0] K [0:63] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] ep0(input logic [31:0] x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic logic [31:0] ep1(input logic [31:0] x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic logic [31:0] sig0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] sig1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  function automatic logic [31:0] ch(input logic [31:0] x, input logic [31:0] y,
                                     input logic [31:0] z);
    return (x & y) ^ (~x & z);
  endfunction

  function automatic logic [31:0] maj(input logic [31:0] x, input logic [31:0] y,
                                      input logic [31:0] z);
    return (x & y) ^ (x & z) ^ (y & z);
  endfunction

endpackage

// File: rtl/sha256_round_unit.sv
// One SHA-256 compression round, purely combinational.
// Latency: 0 cycles. Backpressure: none (no state, no handshake).
// Ports: st_i (a..h in), k_i (round constant), w_i (schedule word), st_o (a..h out).
module sha256_round_unit
  import sha256_pkg::*;
(
  input  work_t       st_i,
  input  logic [31:0] k_i,
  input  logic [31:0] w_i,
  output work_t       st_o
);

  logic [31:0] t1;
  logic [31:0] t2;

  always_comb begin
    t1 = st_i.h + ep1(st_i.e) + ch(st_i.e, st_i.f, st_i.g) + k_i + w_i;
    t2 = ep0(st_i.a) + maj(st_i.a, st_i.b, st_i.c);
    st_o.a = t1 + t2;
    st_o.b = st_i.a;
    st_o.c = st_i.b;
    st_o.d = st_i.c;
    st_o.e = st_i.d + t1;
    st_o.f = st_i.e;
    st_o.g = st_i.f;
    st_o.h = st_i.g;
  end

endmodule

// File: rtl/sha256_core.sv
// Iterative SHA-256 compression of one 512-bit block per accept, chaining H across blocks.
// Latency: out_valid rises 64/R + 1 edges after accept; one block per 64/R + 2 cycles.
// Backpressure: in_ready low while compressing; in_valid is ignored (not latched) then.
// Ports: clk/rst (async active-high), in_valid/in_ready/block_in/chain upstream,
//        out_valid/digest downstream (digest = H, held until the next accept).
module sha256_core
  import sha256_pkg::*;
#(
  parameter int ROUNDS_PER_CYCLE = 1
)(
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [511:0] block_in,
  input  logic         chain,
  output logic         out_valid,
  output logic [255:0] digest
);

  localparam int         R  = ROUNDS_PER_CYCLE;
  localparam logic [6:0] R7 = 7'(ROUNDS_PER_CYCLE);

  if (!(R == 1 || R == 2 || R == 4 || R == 8 || R == 16)) begin : g_bad_rpc
    $error("sha256_core: ROUNDS_PER_CYCLE must be 1, 2, 4, 8 or 16");
  end

  state_e      state_q, state_d;
  work_t       h_q, h_d;
  work_t       work_q, work_d;
  logic [31:0] w_q [0:15];
  logic [31:0] w_d [0:15];
  logic [6:0]  cnt_q, cnt_d;
  logic        out_valid_q, out_valid_d;

  // Window extended by the R words needed after this cycle's slide.
  logic [31:0] w_ext [0:15+R];
  work_t       rnd_out;
  work_t       h_sel;

  // Chain of R rounds; stage i uses K[cnt+i] and the i-th window word.
  for (genvar gi = 0; gi < R; gi++) begin : g_rnd
    work_t      st_in;
    work_t      st_out;
    logic [5:0] k_idx;

    if (gi == 0) begin : g_first
      assign st_in = work_q;
    end else begin : g_next
      assign st_in = g_rnd[gi-1].st_out;
    end

    assign k_idx = cnt_q[5:0] + 6'(gi);

    sha256_round_unit u_round (
      .st_i (st_in),
      .k_i  (K[k_idx]),
      .w_i  (w_q[gi]),
      .st_o (st_out)
    );
  end

  assign rnd_out = g_rnd[R-1].st_out;

  // On-the-fly schedule. On the last ROUND cycle this computes words past 63;
  // they are discarded because the next accept reloads the window.
  always_comb begin
    for (int i = 0; i < 16; i++) begin
      w_ext[i] = w_q[i];
    end
    for (int t = 16; t < 16 + R; t++) begin
      w_ext[t] = sig1(w_ext[t-2]) + w_ext[t-7] + sig0(w_ext[t-15]) + w_ext[t-16];
    end
  end

  // chain=1 reuses H as it stands, which is IV after reset.
  assign h_sel = chain ? h_q : work_t'(IV);

  always_comb begin
    state_d     = state_q;
    h_d         = h_q;
    work_d      = work_q;
    w_d         = w_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;

    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (in_valid) begin
          h_d         = h_sel;
          work_d      = h_sel;
          for (int i = 0; i < 16; i++) begin
            w_d[i] = block_in[511 - 32*i -: 32];
          end
          cnt_d       = 7'd0;
          out_valid_d = 1'b0;
          state_d     = ST_ROUND;
        end
      end
      ST_ROUND: begin
        work_d = rnd_out;
        for (int i = 0; i < 16; i++) begin
          w_d[i] = w_ext[i + R];
        end
        cnt_d = cnt_q + R7;
        if (cnt_d == 7'd64) begin
          state_d = ST_FINAL;
        end
      end
      ST_FINAL: begin
        h_d.a       = h_q.a + work_q.a;
        h_d.b       = h_q.b + work_q.b;
        h_d.c       = h_q.c + work_q.c;
        h_d.d       = h_q.d + work_q.d;
        h_d.e       = h_q.e + work_q.e;
        h_d.f       = h_q.f + work_q.f;
        h_d.g       = h_q.g + work_q.g;
        h_d.h       = h_q.h + work_q.h;
        out_valid_d = 1'b1;
        state_d     = ST_DONE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      h_q         <= work_t'(IV);
      work_q      <= '0;
      cnt_q       <= 7'd0;
      out_valid_q <= 1'b0;
      for (int i = 0; i < 16; i++) begin
        w_q[i] <= 32'd0;
      end
    end else begin
      state_q     <= state_d;
      h_q         <= h_d;
      work_q      <= work_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      for (int i = 0; i < 16; i++) begin
        w_q[i] <= w_d[i];
      end
    end
  end

  assign in_ready  = (state_q == ST_IDLE) || (state_q == ST_DONE);
  assign out_valid = out_valid_q;
  assign digest    = h_q;

endmodule

// File: tb/tb_sha256_core.sv
// Bench for sha256_core: five instances (R = 1, 2, 4, 8, 16) share clock, reset,
// block_in and chain; each has its own in_valid. Expected digests go into a queue
// at stimulus time and are popped when the instance raises out_valid.
module tb_sha256_core;

  logic         clk;
  logic         rst;
  logic [511:0] block_in;
  logic         chain;
  logic [4:0]   in_valid_v;
  logic [4:0]   in_ready_v;
  logic [4:0]   out_valid_v;
  logic [255:0] digest_v [0:4];

  int n_assert = 0;
  int n_fail   = 0;
  logic [255:0] exp_q [$];

  localparam logic [255:0] IV_DIG = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
  localparam logic [255:0] ABC_DIG = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] EMPTY_DIG = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
  localparam logic [255:0] MID_DIG = 256'h85e655d6417a17953363376a624cde5c76e09589cac5f811cc4b32c1f20e533a;
  localparam logic [255:0] TWO_DIG = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

  localparam logic [511:0] ABC_BLK = {32'h61626380, 448'h0, 32'h00000018};
  localparam logic [511:0] EMPTY_BLK = {32'h80000000, 480'h0};
  localparam logic [511:0] TWO_B1 = {
    32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
    32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
    32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
    32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000
  };
  localparam logic [511:0] TWO_B2 = {480'h0, 32'h000001c0};

  for (genvar g = 0; g < 5; g++) begin : g_dut
    sha256_core #(.ROUNDS_PER_CYCLE(1 << g)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid_v[g]),
      .in_ready  (in_ready_v[g]),
      .block_in  (block_in),
      .chain     (chain),
      .out_valid (out_valid_v[g]),
      .digest    (digest_v[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check1(input string tag, input logic got, input logic exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, got, exp);
    end
  endtask

  task automatic check_int(input string tag, input int got, input int exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check256(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Called just after a rising edge with instance d ready. Offers one block,
  // checks the accept edge clears out_valid, counts edges to out_valid.
  task automatic run_block(input int d, input logic [511:0] blk, input logic ch,
                           input logic [255:0] exp_dig, input int exp_lat, input string tag);
    int edges;
    logic [255:0] exp_v;
    check1({tag, "_rdy"}, in_ready_v[d], 1'b1);
    block_in      = blk;
    chain         = ch;
    in_valid_v[d] = 1'b1;
    exp_q.push_back(exp_dig);
    @(posedge clk); #1;
    in_valid_v[d] = 1'b0;
    check1({tag, "_ovfall"}, out_valid_v[d], 1'b0);
    edges = 0;
    while (!out_valid_v[d] && edges < 300) begin
      @(posedge clk); #1;
      edges++;
    end
    check_int({tag, "_lat"}, edges, exp_lat);
    exp_v = exp_q.pop_front();
    check256({tag, "_dig"}, digest_v[d], exp_v);
  endtask

  initial begin
    int edges;
    int bad_rdy;
    logic [255:0] exp_v;

    rst        = 1'b1;
    in_valid_v = 5'b0;
    block_in   = '0;
    chain      = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Reset state on every instance.
    for (int d = 0; d < 5; d++) begin
      check1("rst_ov", out_valid_v[d], 1'b0);
      check1("rst_rdy", in_ready_v[d], 1'b1);
      check256("rst_dig", digest_v[d], IV_DIG);
    end
    rst = 1'b0;
    @(posedge clk); #1;

    // "abc", single block, R=1.
    run_block(0, ABC_BLK, 1'b0, ABC_DIG, 65, "abc_r1");

    // Empty message on all unroll factors.
    for (int d = 0; d < 5; d++) begin
      run_block(d, EMPTY_BLK, 1'b0, EMPTY_DIG, (64 >> d) + 1, "empty");
    end

    // Two-block message, second block accepted in DONE with chain=1.
    run_block(0, TWO_B1, 1'b0, MID_DIG, 65, "two_b1");
    run_block(0, TWO_B2, 1'b1, TWO_DIG, 65, "two_b2");

    // Same two-block message on R=16.
    run_block(4, TWO_B1, 1'b0, MID_DIG, 5, "two_b1_r16");
    run_block(4, TWO_B2, 1'b1, TWO_DIG, 5, "two_b2_r16");

    // in_valid held with a different block while R=1 compresses "abc".
    block_in      = ABC_BLK;
    chain         = 1'b0;
    in_valid_v[0] = 1'b1;
    exp_q.push_back(ABC_DIG);
    @(posedge clk); #1;
    block_in = EMPTY_BLK;
    chain    = 1'b1;
    edges    = 0;
    bad_rdy  = 0;
    while (!out_valid_v[0] && edges < 300) begin
      if (in_ready_v[0]) bad_rdy++;
      @(posedge clk); #1;
      edges++;
    end
    in_valid_v[0] = 1'b0;
    check_int("hold_rdy_high_cycles", bad_rdy, 0);
    check_int("hold_lat", edges, 65);
    exp_v = exp_q.pop_front();
    check256("hold_dig", digest_v[0], exp_v);

    // Reset at round 30 of a block on R=1.
    block_in      = EMPTY_BLK;
    chain         = 1'b0;
    in_valid_v[0] = 1'b1;
    @(posedge clk); #1;
    in_valid_v[0] = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    check1("mid_rdy_busy", in_ready_v[0], 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    check1("mid_rst_ov", out_valid_v[0], 1'b0);
    check1("mid_rst_rdy", in_ready_v[0], 1'b1);
    check256("mid_rst_dig", digest_v[0], IV_DIG);
    rst = 1'b0;
    @(posedge clk); #1;
    run_block(0, ABC_BLK, 1'b1, ABC_DIG, 65, "abc_after_rst");

    check_int("queue_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
